// File: rtl/spi_xfer_ctrl.sv
// SPI master transfer controller: SCLK divider, edge counting, chip-select decode
// and CPOL/CPHA strobe timing for an external shift-register datapath.
module spi_xfer_ctrl #(
    parameter int DATA_WIDTH = 8,
    parameter int CLK_DIV    = 4,
    parameter int NUM_CS     = 2,
    parameter int CS_W       = 1
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_data_valid,
    input  logic [CS_W-1:0]   i_cs_sel,
    input  logic              i_cpol,
    input  logic              i_cpha,
    output logic              o_ready,
    output logic              o_load,
    output logic              o_shift,
    output logic              o_sample,
    output logic              o_sclk,
    output logic [NUM_CS-1:0] o_cs_n,
    output logic              o_busy,
    output logic              o_done
);

    localparam int EDGES  = 2 * DATA_WIDTH;
    localparam int EDGE_W = $clog2(EDGES);
    localparam int DIV_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [EDGE_W-1:0] LAST_EDGE = EDGE_W'(EDGES - 1);
    localparam logic [DIV_W-1:0]  DIV_TC    = DIV_W'(CLK_DIV - 1);

    typedef enum logic [1:0] {IDLE, LOAD, TRANS, GAP} state_t;

    state_t              state, state_next;
    logic [DIV_W-1:0]    div_cnt, div_next;
    logic [EDGE_W-1:0]   edge_cnt, edge_next;
    logic [CS_W-1:0]     cs_q, cs_next;
    logic                cpol_q, cpol_next;
    logic                cpha_q, cpha_next;
    logic                pending, pending_next;
    logic                sclk_next;
    logic [NUM_CS-1:0]   cs_n_next;
    logic                tc, last_edge, accept, same_cfg, sample_edge;

    // Out-of-range selects decode to no active line at all
    function automatic logic [NUM_CS-1:0] decode_cs(input logic [CS_W-1:0] sel);
        logic [NUM_CS-1:0] dec;
        dec = '1;
        for (int i = 0; i < NUM_CS; i++) begin
            if (sel == CS_W'(i)) dec[i] = 1'b0;
        end
        return dec;
    endfunction

    assign tc          = (div_cnt == DIV_TC);
    assign last_edge   = (state == TRANS) && tc && (edge_cnt == LAST_EDGE);
    assign o_ready     = (state == IDLE) || last_edge;
    assign o_busy      = (state != IDLE);
    assign accept      = i_data_valid && o_ready;
    assign same_cfg    = (i_cs_sel == cs_q) && (i_cpol == cpol_q) && (i_cpha == cpha_q);
    assign sample_edge = cpha_q ? edge_cnt[0] : ~edge_cnt[0];

    always_comb begin
        state_next   = state;
        div_next     = div_cnt;
        edge_next    = edge_cnt;
        cs_next      = cs_q;
        cpol_next    = cpol_q;
        cpha_next    = cpha_q;
        pending_next = pending;
        o_load       = 1'b0;
        o_shift      = 1'b0;
        o_sample     = 1'b0;
        o_done       = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    cs_next    = i_cs_sel;
                    cpol_next  = i_cpol;
                    cpha_next  = i_cpha;
                    state_next = LOAD;
                end
            end
            LOAD: begin
                o_load     = 1'b1;
                div_next   = '0;
                edge_next  = '0;
                state_next = TRANS;
            end
            TRANS: begin
                o_sample = tc && sample_edge;
                // With CPHA=1 the load already put bit 0 on the line
                o_shift  = tc && !sample_edge && !(cpha_q && (edge_cnt == '0));
                if (tc) begin
                    div_next  = '0;
                    edge_next = edge_cnt + 1'b1;
                end else begin
                    div_next = div_cnt + 1'b1;
                end
                if (last_edge) begin
                    o_done    = 1'b1;
                    edge_next = '0;
                    if (accept && same_cfg) begin
                        state_next = LOAD;
                    end else begin
                        if (accept) begin
                            cs_next      = i_cs_sel;
                            cpol_next    = i_cpol;
                            cpha_next    = i_cpha;
                            pending_next = 1'b1;
                        end
                        state_next = GAP;
                    end
                end
            end
            GAP: begin
                if (tc) begin
                    div_next     = '0;
                    pending_next = 1'b0;
                    state_next   = pending ? LOAD : IDLE;
                end else begin
                    div_next = div_cnt + 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // SCLK and selects are registered, so they are computed for the upcoming state
    always_comb begin
        sclk_next = cpol_next;
        cs_n_next = '1;
        if (state_next == TRANS) begin
            sclk_next = ((state == TRANS) && tc) ? ~o_sclk : o_sclk;
        end
        if ((state_next == LOAD) || (state_next == TRANS)) begin
            cs_n_next = decode_cs(cs_next);
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state    <= IDLE;
            div_cnt  <= '0;
            edge_cnt <= '0;
            cs_q     <= '0;
            cpol_q   <= 1'b0;
            cpha_q   <= 1'b0;
            pending  <= 1'b0;
            o_sclk   <= 1'b0;
            o_cs_n   <= '1;
        end else begin
            state    <= state_next;
            div_cnt  <= div_next;
            edge_cnt <= edge_next;
            cs_q     <= cs_next;
            cpol_q   <= cpol_next;
            cpha_q   <= cpha_next;
            pending  <= pending_next;
            o_sclk   <= sclk_next;
            o_cs_n   <= cs_n_next;
        end
    end

endmodule
